// File: rtl/reversible_serial_unadder_pkg.sv
// Shared definitions for the reversible serial un-adder.
//   - state_e : FSM state encoding (IDLE, RUN, DONE)
//   - RA_W    : default operand width
//   - cnt_w() : width of the bit counter, clog2(w) with a floor of 1
package reversible_pkg;

  localparam int RA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A single-bit operand still needs a 1-bit counter.
  function automatic int cnt_w(input int w);
    if (w <= 1) begin
      return 1;
    end else begin
      return $clog2(w);
    end
  endfunction

endpackage

// File: rtl/reversible_serial_unadder_if.sv
// Job/result handshake bundle of the reversible serial un-adder.
//   Request : in_valid, in_ready, in_a[W-1:0], in_s[W:0], in_cin
//   Result  : out_valid, out_ready, out_b[W-1:0], out_a[W-1:0], out_cin, out_err
//   master  : producer of jobs / consumer of results
//   slave   : the un-adder itself
interface reversible_serial_unadder_if #(
  parameter int W = reversible_pkg::RA_W
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W:0]   in_s;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_b;
  logic [W-1:0] out_a;
  logic         out_cin;
  logic         out_err;

  modport master (
    output in_valid, in_a, in_s, in_cin, out_ready,
    input  in_ready, out_valid, out_b, out_a, out_cin, out_err
  );

  modport slave (
    input  in_valid, in_a, in_s, in_cin, out_ready,
    output in_ready, out_valid, out_b, out_a, out_cin, out_err
  );

endinterface

// File: rtl/reversible_serial_unadder_cell.sv
// Inverse Peres-gate pair for one bit position (purely combinational).
//   a_i    : preserved operand bit
//   s_i    : sum bit
//   cin_i  : carry into this bit
//   b_o    : recovered operand bit
//   cout_o : regenerated carry out of this bit
module inverse_peres_cell (
  input  logic a_i,
  input  logic s_i,
  input  logic cin_i,
  output logic b_o,
  output logic cout_o
);

  logic ab_x_s;

  // Undo the sum XOR first, then rebuild the carry Peres-style:
  // majority(a, b, c) written as (a & b) ^ (c & (a ^ b)).
  assign b_o    = s_i ^ a_i ^ cin_i;
  assign ab_x_s = a_i ^ b_o;
  assign cout_o = (a_i & b_o) ^ (cin_i & ab_x_s);

endmodule

// File: rtl/reversible_serial_unadder.sv
// Bit-serial inverse of a reversible ripple adder. Accepts (A, S, CIN),
// recovers B one bit per cycle LSB first through a single time-multiplexed
// inverse Peres cell, and flags out_err when the regenerated carry-out
// disagrees with S[W].
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : job/result handshake (slave side)
module reversible_serial_unadder
  import reversible_pkg::*;
#(
  parameter int W = RA_W
) (
  input logic                        clk,
  input logic                        rst_n,
  reversible_serial_unadder_if.slave bus
);

  localparam int            CW   = cnt_w(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W:0]    s_q, s_d;
  logic          cin_q, cin_d;
  logic [W-1:0]  b_q, b_d;
  logic          err_q, err_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic          bit_b;
  logic          bit_cout;

  inverse_peres_cell u_cell (
    .a_i    (a_q[count_q]),
    .s_i    (s_q[count_q]),
    .cin_i  (carry_q),
    .b_o    (bit_b),
    .cout_o (bit_cout)
  );

  // Next-state, datapath and handshake decode.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    carry_d     = carry_q;
    a_d         = a_q;
    s_d         = s_q;
    cin_d       = cin_q;
    b_d         = b_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d        = bus.in_a;
          s_d        = bus.in_s;
          cin_d      = bus.in_cin;
          carry_d    = bus.in_cin;
          count_d    = '0;
          b_d        = '0;
          err_d      = 1'b0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end else begin
          in_ready_d = 1'b1;
        end
      end

      RUN: begin
        b_d[count_q] = bit_b;
        carry_d      = bit_cout;
        if (count_q == LAST) begin
          // Final bit: the carry leaving it must reproduce the adder carry-out.
          err_d       = (bit_cout != s_q[W]);
          count_d     = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      s_q         <= '0;
      cin_q       <= 1'b0;
      b_q         <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      s_q         <= s_d;
      cin_q       <= cin_d;
      b_q         <= b_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_b     = b_q;
  assign bus.out_a     = a_q;
  assign bus.out_cin   = cin_q;
  assign bus.out_err   = err_q;

endmodule

// File: doc/reversible_serial_unadder.md
Name: reversible_serial_unadder

Overview:
- Bit-serial inverse of the reversible full-adder chain: given a preserved operand A, the carry-in, and the (W+1)-bit sum word S (carry-out in the MSB), it recovers operand B one bit per cycle.
- Each bit uses the inverse Peres-gate pair: the uncompute stage that runs after a reversible adder, returning garbage lines to operand values.
- Also checks that the regenerated carry-out matches S[W] and flags any mismatch.
- Sits downstream of the adder datapath behind a valid/ready handshake.

Parameters:
- W, 8, operand width in bits (W >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  S/A/CIN valid.
- in_ready  output  1  block can accept a job.
- in_a  input  W  preserved operand A.
- in_s  input  W+1  sum word; bit W is the adder carry-out.
- in_cin  input  1  original carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_b  output  W  recovered operand B.
- out_a  output  W  A passed through unchanged.
- out_cin  output  1  CIN passed through unchanged.
- out_err  output  1  regenerated carry-out differs from in_s[W].

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values:
  - state=IDLE, count=0, carry=0.
  - All result registers are 0.
  - out_valid=0, out_err=0, in_ready=1 once reset is released.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, latch A, S and CIN; set carry=CIN and count=0; go to RUN.
- RUN (in_ready=0, out_valid=0), each cycle with i=count:
  - b_i = s_i ^ a_i ^ carry.
  - carry <= (a_i & b_i) ^ (carry & (a_i ^ b_i)).
  - b_i is written into a shift or indexed register at position i; count increments.
  - After the cycle with count=W-1, go to DONE. In the same edge, register out_err = (carry_next != S[W]).
- DONE:
  - out_valid=1; out_b, out_a, out_cin and out_err are held stable.
  - On out_ready, go to IDLE; out_valid drops on that edge.
  - With out_ready held low, outputs are held indefinitely (backpressure).
- Latency:
  - out_valid rises exactly W rising edges after the accepting edge.
  - Minimum initiation interval is W+2 cycles: in_ready returns the cycle after the output handshake.
  - No overlap of accept and complete.
- Arithmetic is modulo 2^W for B.
  - A carry-chain mismatch is reported only via out_err; out_b is still the bit-serial result.
- Boundary cases:
  - W=1: RUN lasts one cycle.
  - in_valid asserted outside IDLE is ignored (not latched).
  - Input data changes during RUN have no effect.
  - rst_n asserted mid-RUN or mid-DONE aborts immediately: outputs go to reset values and no partial result is ever presented.
  - out_ready asserted while not in DONE is ignored.

Decomposition:
- Shared package (reversible_pkg):
  - state enum {IDLE, RUN, DONE}.
  - Default width constant RA_W=8.
  - Counter width function, clog2(W) with a minimum of 1.
- Sub-module inverse_peres_cell, purely combinational:
  - Inputs: a, s, cin.
  - Outputs: b, cout.
  - Instantiated once and time-multiplexed across bits.
- The top level holds the FSM, counter, and A/S/B registers.

Test Plan (W=8):
- Accept A=0x35, S=0x07F, CIN=0 -> after exactly 8 edges: out_valid=1, out_b=0x4A, out_a=0x35, out_err=0.
- A=0xFF, S=0x101, CIN=1 -> out_b=0x01, out_err=0 (full carry ripple).
- A=0x35, S=0x17F, CIN=0 -> out_b=0x4A, out_err=1 (carry-out mismatch).
- A=0x00, S=0x000, CIN=1 -> out_b=0xFF, out_err=1 (wrap-around case).
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0. Then pulse out_ready -> out_valid=0 next cycle and in_ready=1. A second job accepted immediately completes correctly.
- Reset mid-run: assert rst_n=0 at RUN count=3 -> out_valid stays 0 and in_ready=1 after release. A new job (A=0x10, S=0x030, CIN=0) -> out_b=0x20, out_err=0.
- Random: 1000 random A, B, CIN with S=A+B+CIN -> out_b=B and out_err=0 on every job.
